// File: rtl/sfr_access_master.sv
// CPU-side initiator for the SFR byte/bit port: decodes direct/bit addresses and sequences
// read, write and bit-complement strobes. Optional SFR_WRITE_VERIFY_EN adds write read-back.
module sfr_access_master #(
  parameter int unsigned Width   = 8,
  parameter logic [7:0]  SfrBase = 8'h80
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_op_i,
  input  logic             req_bit_i,
  input  logic [7:0]       req_addr_i,
  input  logic [Width-1:0] req_data_i,
  input  logic             req_bin_i,
  output logic             rsp_valid_o,
  output logic [Width-1:0] rsp_data_o,
  output logic             rsp_bit_o,
  output logic             rsp_err_o,
  output logic [7:0]       sfr_addr_o,
  output logic             sfr_en_o,
  output logic             sfr_oe_o,
  output logic             sfr_bb_o,
  output logic [Width-1:0] sfr_pos_o,
  output logic [Width-1:0] sfr_din_o,
  output logic             sfr_bin_o,
  input  logic [Width-1:0] sfr_dout_i,
  input  logic             sfr_bout_i
);

  localparam logic [1:0] OpRead  = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpCpl   = 2'b10;

`ifdef SFR_WRITE_VERIFY_EN
  typedef enum logic [2:0] {
    StIdle, StRdIssue, StRdWait, StWrIssue, StVfIssue, StVfWait, StDone
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StRdIssue, StRdWait, StWrIssue, StDone
  } state_e;
`endif

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             bit_q, bit_d;
  logic [7:0]       addr_q, addr_d;
  logic [Width-1:0] pos_q, pos_d;
  logic             bb_q, bb_d;
  logic [Width-1:0] din_q, din_d;
  logic             bin_q, bin_d;
  logic [Width-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_bit_q, rsp_bit_d;
  logic             rsp_err_q, rsp_err_d;
  logic             reject;

  assign reject = (req_addr_i < SfrBase) || (req_op_i == 2'b11) ||
                  ((req_op_i == OpCpl) && !req_bit_i);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    bit_d      = bit_q;
    addr_d     = addr_q;
    pos_d      = pos_q;
    bb_d       = bb_q;
    din_d      = din_q;
    bin_d      = bin_q;
    rsp_data_d = rsp_data_q;
    rsp_bit_d  = rsp_bit_q;
    rsp_err_d  = rsp_err_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          op_d  = req_op_i;
          bit_d = req_bit_i;
          din_d = req_data_i;
          bin_d = req_bin_i;
          if (req_bit_i) begin
            addr_d = {req_addr_i[7:3], 3'b000};
            pos_d  = Width'(1) << req_addr_i[2:0];
            bb_d   = 1'b0;
          end else begin
            addr_d = req_addr_i;
            pos_d  = '0;
            bb_d   = 1'b1;
          end
          if (reject) begin
            state_d    = StDone;
            rsp_data_d = '0;
            rsp_bit_d  = 1'b0;
            rsp_err_d  = 1'b1;
          end else if (req_op_i == OpWrite) begin
            state_d = StWrIssue;
          end else begin
            state_d = StRdIssue;
          end
        end
      end
      StRdIssue: state_d = StRdWait;
      StRdWait: begin
        // Registered SFR data is only driven in the cycle after oe.
        if (op_q == OpCpl) begin
          bin_d   = ~sfr_bout_i;
          state_d = StWrIssue;
        end else begin
          state_d    = StDone;
          rsp_data_d = bit_q ? '0 : sfr_dout_i;
          rsp_bit_d  = bit_q & sfr_bout_i;
          rsp_err_d  = 1'b0;
        end
      end
      StWrIssue: begin
`ifdef SFR_WRITE_VERIFY_EN
        state_d = StVfIssue;
`else
        state_d    = StDone;
        rsp_data_d = (op_q == OpCpl) ? '0 : din_q;
        rsp_bit_d  = bin_q;
        rsp_err_d  = 1'b0;
`endif
      end
`ifdef SFR_WRITE_VERIFY_EN
      StVfIssue: state_d = StVfWait;
      StVfWait: begin
        state_d    = StDone;
        rsp_data_d = (op_q == OpCpl) ? '0 : din_q;
        rsp_bit_d  = bin_q;
        rsp_err_d  = bit_q ? (sfr_bout_i != bin_q) : (sfr_dout_i != din_q);
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      op_q       <= OpRead;
      bit_q      <= 1'b0;
      addr_q     <= '0;
      pos_q      <= '0;
      bb_q       <= 1'b1;
      din_q      <= '0;
      bin_q      <= 1'b0;
      rsp_data_q <= '0;
      rsp_bit_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      bit_q      <= bit_d;
      addr_q     <= addr_d;
      pos_q      <= pos_d;
      bb_q       <= bb_d;
      din_q      <= din_d;
      bin_q      <= bin_d;
      rsp_data_q <= rsp_data_d;
      rsp_bit_q  <= rsp_bit_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign req_ready_o = (state_q == StIdle);
  assign rsp_valid_o = (state_q == StDone);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_bit_o   = rsp_bit_q;
  assign rsp_err_o   = rsp_err_q;
`ifdef SFR_WRITE_VERIFY_EN
  assign sfr_oe_o    = (state_q == StRdIssue) || (state_q == StVfIssue);
`else
  assign sfr_oe_o    = (state_q == StRdIssue);
`endif
  assign sfr_en_o    = (state_q == StWrIssue);
  assign sfr_addr_o  = addr_q;
  assign sfr_bb_o    = bb_q;
  assign sfr_pos_o   = pos_q;
  assign sfr_din_o   = din_q;
  assign sfr_bin_o   = bin_q;

endmodule
